// File: rtl/counter_x_pkg.sv
// counter_x_pkg
//   Shared constants for the three-channel programmable timer: output mode
//   encodings, the bus select code that addresses the control register, and
//   the layout of the per-channel fields inside the 24-bit control register.
package counter_x_pkg;

    localparam int NUM_CH = 3;

    // Channel output modes (ctrl bits [8n+1:8n])
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RATE    = 2'b01;
    localparam logic [1:0] MODE_SQUARE  = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    // counter_ch_sel value that targets the control register
    localparam logic [1:0] SEL_CTRL = 2'b11;

    // Control register layout: one byte per channel, only 3 bits used
    localparam int          CTRL_W    = 24;
    localparam int          CH_STRIDE = 8;
    localparam int          MODE_LSB  = 0;
    localparam int          EN_BIT    = 2;
    localparam logic [23:0] CTRL_MASK = 24'h070707;

endpackage

// File: rtl/counter_x_ch.sv
// counter_x_ch
//   One timer channel: a down-counter with a reload register and a registered
//   output whose behaviour depends on the selected mode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : write strobe for this channel (takes priority over tick)
//   load_val   : value written to both reload and count
//   tick       : single-cycle count enable from the prescaler
//   en         : channel enable from the control register
//   mode       : output mode from the control register
//   count      : current count (for bus readback)
//   out        : channel output, registered
module counter_x_ch
    import counter_x_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] count,
    output logic             out
);

    logic [CNT_W-1:0] reload;
    logic             count_gt1;
    logic             count_is1;
    logic             reload_nz;

    assign count_gt1 = (count > CNT_W'(1));
    assign count_is1 = (count == CNT_W'(1));
    assign reload_nz = (reload != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            reload <= '0;
            out    <= 1'b0;
        end else if (load) begin
            // A load discards any tick arriving in the same cycle
            count  <= load_val;
            reload <= load_val;
            out    <= 1'b0;
        end else begin
            // Rate-mode output is a one-clock pulse: it drops on the edge after
            // it rises regardless of tick or enable; a reload below re-raises it.
            if (mode == MODE_RATE) begin
                out <= 1'b0;
            end
            if (tick && en) begin
                case (mode)
                    MODE_ONESHOT: begin
                        if (count_gt1) begin
                            count <= count - CNT_W'(1);
                        end else if (count_is1) begin
                            count <= '0;
                            out   <= 1'b1;
                        end
                    end
                    MODE_RATE: begin
                        if (count_gt1) begin
                            count <= count - CNT_W'(1);
                        end else if (reload_nz) begin
                            count <= reload;
                            out   <= 1'b1;
                        end
                    end
                    MODE_SQUARE: begin
                        if (count_gt1) begin
                            count <= count - CNT_W'(1);
                        end else if (reload_nz) begin
                            count <= reload;
                            out   <= ~out;
                        end
                    end
                    default: ; // MODE_HOLD: frozen
                endcase
            end
        end
    end

endmodule

// File: rtl/counter_x.sv
// counter_x
//   Three-channel programmable timer behind the MMIO bus decoder. Holds the
//   control register, decodes bus writes to a channel or to control, and
//   provides the combinational read-back mux.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   counter_we       : write strobe from the bus decoder
//   Peripheral_in    : write data
//   counter_ch_sel   : 0..2 selects a channel, 3 selects the control register
//   cnt_tick         : single-cycle count enable from the prescaler
//   counter_out      : read data (same-cycle, follows counter_ch_sel)
//   counter0/1/2_out : registered channel outputs
module counter_x
    import counter_x_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        counter_we,
    input  logic [31:0] Peripheral_in,
    input  logic [1:0]  counter_ch_sel,
    input  logic        cnt_tick,
    output logic [31:0] counter_out,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out
);

    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  ch_count [NUM_CH];
    logic [NUM_CH-1:0] ch_out;

    // The channels see the pre-write ctrl on the write edge, so a tick in the
    // same cycle as a control write is evaluated under the old settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
        end else if (counter_we && (counter_ch_sel == SEL_CTRL)) begin
            ctrl <= Peripheral_in[CTRL_W-1:0] & CTRL_MASK;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        counter_x_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (counter_we && (counter_ch_sel == 2'(n))),
            .load_val (Peripheral_in[CNT_W-1:0]),
            .tick     (cnt_tick),
            .en       (ctrl[n*CH_STRIDE+EN_BIT]),
            .mode     (ctrl[n*CH_STRIDE+MODE_LSB +: 2]),
            .count    (ch_count[n]),
            .out      (ch_out[n])
        );
    end

    assign counter0_out = ch_out[0];
    assign counter1_out = ch_out[1];
    assign counter2_out = ch_out[2];

    always_comb begin
        counter_out = '0;
        case (counter_ch_sel)
            2'd0:     counter_out = 32'(ch_count[0]);
            2'd1:     counter_out = 32'(ch_count[1]);
            2'd2:     counter_out = 32'(ch_count[2]);
            default:  counter_out = {8'h00, ctrl};
        endcase
    end

endmodule

// File: tb/tb_counter_x.sv
// tb_counter_x
//   Directed and randomized stimulus for counter_x, checked against a
//   behavioural model of the timer kept in the bench.
module tb_counter_x;

    logic        clk;
    logic        rst_n;
    logic        counter_we;
    logic [31:0] Peripheral_in;
    logic [1:0]  counter_ch_sel;
    logic        cnt_tick;
    logic [31:0] counter_out;
    logic        counter0_out;
    logic        counter1_out;
    logic        counter2_out;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_count  [0:2];
    logic [31:0] m_reload [0:2];
    bit          m_out    [0:2];
    logic [23:0] m_ctrl;

    counter_x #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .counter_we     (counter_we),
        .Peripheral_in  (Peripheral_in),
        .counter_ch_sel (counter_ch_sel),
        .cnt_tick       (cnt_tick),
        .counter_out    (counter_out),
        .counter0_out   (counter0_out),
        .counter1_out   (counter1_out),
        .counter2_out   (counter2_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            m_count[ch]  = '0;
            m_reload[ch] = '0;
            m_out[ch]    = 1'b0;
        end
        m_ctrl = '0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [23:0] old_ctrl;
        int unsigned md;
        bit          en;
        old_ctrl = m_ctrl;
        if (counter_we && counter_ch_sel == 2'd3)
            m_ctrl = Peripheral_in[23:0] & 24'h070707;
        for (int ch = 0; ch < 3; ch++) begin
            md = 32'(old_ctrl[8*ch +: 2]);
            en = old_ctrl[8*ch+2];
            if (counter_we && counter_ch_sel == 2'(ch)) begin
                m_count[ch]  = Peripheral_in;
                m_reload[ch] = Peripheral_in;
                m_out[ch]    = 1'b0;
                continue;
            end
            if (md == 1) m_out[ch] = 1'b0;
            if (!(cnt_tick && en) || md == 3) continue;
            if (m_count[ch] > 1) begin
                m_count[ch] = m_count[ch] - 1;
            end else if (md == 0) begin
                if (m_count[ch] == 1) begin
                    m_count[ch] = 0;
                    m_out[ch]   = 1'b1;
                end
            end else if (m_reload[ch] != 0) begin
                m_count[ch] = m_reload[ch];
                m_out[ch]   = (md == 1) ? 1'b1 : !m_out[ch];
            end
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [1:0] sel);
        return (sel == 2'd3) ? {8'h00, m_ctrl} : m_count[sel];
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out0"}, {31'b0, counter0_out}, {31'b0, m_out[0]});
        check({tag, "_out1"}, {31'b0, counter1_out}, {31'b0, m_out[1]});
        check({tag, "_out2"}, {31'b0, counter2_out}, {31'b0, m_out[2]});
        check({tag, "_rd"}, counter_out, exp_read(counter_ch_sel));
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic cycle(input logic we, input logic [1:0] sel,
                         input logic [31:0] data, input logic tick, input string tag);
        counter_we     = we;
        counter_ch_sel = sel;
        Peripheral_in  = data;
        cnt_tick       = tick;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Same-cycle read of every select code, no clock edge involved.
    task automatic read_all(input string tag);
        counter_we = 1'b0;
        cnt_tick   = 1'b0;
        for (int s = 0; s < 4; s++) begin
            counter_ch_sel = 2'(s);
            #1;
            check({tag, "_rdall"}, counter_out, exp_read(2'(s)));
        end
    endtask

    task automatic read_sel(input logic [1:0] sel, input logic [31:0] exp, input string tag);
        counter_we     = 1'b0;
        cnt_tick       = 1'b0;
        counter_ch_sel = sel;
        #1;
        check(tag, counter_out, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd_exp;
        counter_we     = 1'b0;
        counter_ch_sel = 2'd0;
        Peripheral_in  = '0;
        cnt_tick       = 1'b0;
        rst_n          = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out0", {31'b0, counter0_out}, 32'd0);
        check("rst_out1", {31'b0, counter1_out}, 32'd0);
        check("rst_out2", {31'b0, counter2_out}, 32'd0);
        check("rst_rd", counter_out, 32'd0);
        rst_n = 1'b1;

        // Ticks with nothing written do nothing
        repeat (4) cycle(1'b0, 2'd0, 32'd0, 1'b1, "idle");
        read_all("idle");

        // One-shot on ch0
        cycle(1'b1, 2'd3, 32'h0000_0004, 1'b0, "os_ctrl");
        cycle(1'b1, 2'd0, 32'd3, 1'b0, "os_load");
        cycle(1'b0, 2'd0, 32'd0, 1'b1, "os_t1");
        check("os_t1_low", {31'b0, counter0_out}, 32'd0);
        cycle(1'b0, 2'd0, 32'd0, 1'b1, "os_t2");
        check("os_t2_low", {31'b0, counter0_out}, 32'd0);
        cycle(1'b0, 2'd0, 32'd0, 1'b1, "os_t3");
        check("os_t3_high", {31'b0, counter0_out}, 32'd1);
        check("os_t3_cnt", counter_out, 32'd0);
        cycle(1'b0, 2'd0, 32'd0, 1'b1, "os_t4");
        check("os_t4_high", {31'b0, counter0_out}, 32'd1);
        cycle(1'b1, 2'd0, 32'd5, 1'b0, "os_reload");
        check("os_reload_low", {31'b0, counter0_out}, 32'd0);

        // Rate generator on ch1, tick every second clock
        cycle(1'b1, 2'd3, 32'h0000_0500, 1'b0, "rate_ctrl");
        cycle(1'b1, 2'd1, 32'd4, 1'b0, "rate_load");
        check("rate_load_rd", counter_out, 32'd4);
        for (int i = 0; i < 20; i++) begin
            int tn;
            bit tk;
            tk = (i % 2 == 0);
            tn = i / 2 + 1;
            cycle(1'b0, 2'd1, 32'd0, tk, "rate");
            check("rate_pulse", {31'b0, counter1_out}, {31'b0, (tk && (tn % 4 == 0))});
            rd_exp = (tn % 4 == 0) ? 32'd4 : 32'(4 - (tn % 4));
            check("rate_cnt", counter_out, rd_exp);
        end

        // Square wave on ch2, continuous ticks
        cycle(1'b1, 2'd3, 32'h0006_0000, 1'b0, "sq_ctrl");
        cycle(1'b1, 2'd2, 32'd2, 1'b0, "sq_load");
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 2'd2, 32'd0, 1'b1, "sq");
            check("sq_wave", {31'b0, counter2_out}, 32'((k / 2) % 2));
        end
        cycle(1'b1, 2'd2, 32'd0, 1'b0, "sq_zero");
        repeat (6) cycle(1'b0, 2'd2, 32'd0, 1'b1, "sq_hold");
        check("sq_hold_out", {31'b0, counter2_out}, 32'd0);
        check("sq_hold_cnt", counter_out, 32'd0);

        // Load and tick collide
        cycle(1'b1, 2'd3, 32'h0000_0504, 1'b0, "col_ctrl");
        cycle(1'b1, 2'd1, 32'd20, 1'b0, "col_l1");
        cycle(1'b1, 2'd0, 32'd10, 1'b1, "col");
        read_sel(2'd0, 32'd10, "col_ch0");
        read_sel(2'd1, 32'd19, "col_ch1");

        // Control readback masking
        @(negedge clk);
        cycle(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, "ctrl_all");
        check("ctrl_mask", counter_out, 32'h0007_0707);

        // Enable freeze and resume
        cycle(1'b1, 2'd3, 32'h0000_0004, 1'b0, "frz_ctrl");
        cycle(1'b1, 2'd0, 32'd8, 1'b0, "frz_load");
        repeat (2) cycle(1'b0, 2'd0, 32'd0, 1'b1, "frz_run");
        check("frz_run_cnt", counter_out, 32'd6);
        cycle(1'b1, 2'd3, 32'h0000_0000, 1'b0, "frz_dis");
        repeat (3) cycle(1'b0, 2'd0, 32'd0, 1'b1, "frz_hold");
        check("frz_hold_cnt", counter_out, 32'd6);
        cycle(1'b1, 2'd3, 32'h0000_0004, 1'b0, "frz_en");
        cycle(1'b0, 2'd0, 32'd0, 1'b1, "frz_resume");
        check("frz_resume_cnt", counter_out, 32'd5);

        // Randomized traffic
        for (int r = 0; r < 600; r++) begin
            logic        we;
            logic [1:0]  sel;
            logic [31:0] data;
            we  = ($urandom_range(0, 5) == 0);
            sel = 2'($urandom_range(0, 3));
            if (sel == 2'd3 || $urandom_range(0, 15) == 0)
                data = $urandom;
            else
                data = 32'($urandom_range(0, 9));
            cycle(we, sel, data, 1'($urandom_range(0, 2) != 0), "rnd");
            if (r % 50 == 49) read_all("rnd");
        end

        // Asynchronous reset in the middle of counting
        cycle(1'b1, 2'd3, 32'h0006_0504, 1'b0, "mrst_ctrl");
        cycle(1'b1, 2'd0, 32'd1, 1'b0, "mrst_l0");
        cycle(1'b1, 2'd2, 32'd1, 1'b0, "mrst_l2");
        cycle(1'b0, 2'd2, 32'd0, 1'b1, "mrst_run");
        counter_ch_sel = 2'd3;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst_out0", {31'b0, counter0_out}, 32'd0);
        check("mrst_out2", {31'b0, counter2_out}, 32'd0);
        check("mrst_rd", counter_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 2'd0, 32'd0, 1'b1, "post_rst");
        read_all("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
